// File: rtl/hazard_ctrl_if.sv
// Hazard controller interface: D/X/M stage register info and control inputs
// from the pipeline, forwarding/stall/flush/freeze controls and perf counters back.
interface hazard_ctrl_if;
    // D-stage sources
    logic [4:0]  d_rs_a;
    logic [4:0]  d_rt_a;
    logic        d_rs_used;
    logic        d_rt_used;
    // X-stage destination
    logic [4:0]  x_rd_a;
    logic        x_reg_write;
    logic        x_mem_read;
    // M-stage destination
    logic [4:0]  m_rd_a;
    logic        m_reg_write;
    // Control events
    logic        branch_taken;
    logic        mem_busy;
    // Controls to the pipeline
    logic        fwdX_rs;
    logic        fwdX_rt;
    logic        fwdM_rs;
    logic        fwdM_rt;
    logic        stall;
    logic        stall_fd;
    logic        flush;
    logic        freeze;
    // Performance counters
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;

    // Controller side
    modport master (
        input  d_rs_a, d_rt_a, d_rs_used, d_rt_used,
        input  x_rd_a, x_reg_write, x_mem_read,
        input  m_rd_a, m_reg_write,
        input  branch_taken, mem_busy,
        output fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt,
        output stall, stall_fd, flush, freeze,
        output stall_cycles, flush_events
    );

    // Pipeline side
    modport slave (
        output d_rs_a, d_rt_a, d_rs_used, d_rt_used,
        output x_rd_a, x_reg_write, x_mem_read,
        output m_rd_a, m_reg_write,
        output branch_taken, mem_busy,
        input  fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt,
        input  stall, stall_fd, flush, freeze,
        input  stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection / forwarding controller. Combinational forwarding selects,
// load-use stall sequencing, taken-branch flush sequencing, memory-busy freeze
// and stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_LAT   = 1,  // bubble cycles per load-use hazard (1..7)
    parameter int unsigned BR_PENALTY = 2   // flush cycles per taken branch (1..7)
) (
    input logic           clk,
    input logic           rst,
    hazard_ctrl_if.master hz
);

    typedef enum logic [1:0] {
        RUN,
        LSTALL,
        FLUSH
    } state_t;

    // The detecting cycle already supplies the first bubble / flush, so the held
    // states only cover the remaining LAT-1 cycles; cnt counts those down to 0.
    localparam bit          LS_HOLD = (LOAD_LAT > 1);
    localparam bit          FL_HOLD = (BR_PENALTY > 1);
    localparam int unsigned LS_REM  = LS_HOLD ? LOAD_LAT - 2 : 0;
    localparam int unsigned FL_REM  = FL_HOLD ? BR_PENALTY - 2 : 0;
    localparam logic [2:0]  LS_CNT  = 3'(LS_REM);
    localparam logic [2:0]  FL_CNT  = 3'(FL_REM);

    state_t      state;
    state_t      state_n;
    logic [2:0]  cnt;
    logic [2:0]  cnt_n;

    logic        rs_nz;
    logic        rt_nz;
    logic        rs_x_hit;
    logic        rt_x_hit;
    logic        fx_rs;
    logic        fx_rt;
    logic        fm_rs;
    logic        fm_rt;
    logic        load_use;

    logic        stall_i;
    logic        flush_i;
    logic        freeze_i;

    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Source/destination comparison: forwarding selects and load-use detection
    always_comb begin
        rs_nz    = (hz.d_rs_a != 5'd0);
        rt_nz    = (hz.d_rt_a != 5'd0);
        rs_x_hit = hz.d_rs_used & hz.x_reg_write & rs_nz & (hz.x_rd_a == hz.d_rs_a);
        rt_x_hit = hz.d_rt_used & hz.x_reg_write & rt_nz & (hz.x_rd_a == hz.d_rt_a);
        fx_rs    = rs_x_hit & ~hz.x_mem_read;
        fx_rt    = rt_x_hit & ~hz.x_mem_read;
        fm_rs    = hz.d_rs_used & hz.m_reg_write & rs_nz & (hz.m_rd_a == hz.d_rs_a) & ~fx_rs;
        fm_rt    = hz.d_rt_used & hz.m_reg_write & rt_nz & (hz.m_rd_a == hz.d_rt_a) & ~fx_rt;
        load_use = hz.x_mem_read & (rs_x_hit | rt_x_hit);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state: branch beats memory-busy, which beats load-use
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (hz.branch_taken) begin
            if (FL_HOLD) begin
                state_n = FLUSH;
                cnt_n   = FL_CNT;
            end else begin
                state_n = RUN;
                cnt_n   = '0;
            end
        end else if (hz.mem_busy) begin
            state_n = state;
            cnt_n   = cnt;
        end else begin
            case (state)
                RUN: begin
                    if (load_use && LS_HOLD) begin
                        state_n = LSTALL;
                        cnt_n   = LS_CNT;
                    end
                end
                LSTALL, FLUSH: begin
                    if (cnt == 3'd0) begin
                        state_n = RUN;
                    end else begin
                        cnt_n = cnt - 3'd1;
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs: held-state values plus same-cycle detection, all gated by reset
    always_comb begin
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        freeze_i = 1'b0;
        if (rst) begin
            stall_i  = ~hz.branch_taken &
                       ((state == LSTALL) | ((state == RUN) & load_use & ~hz.mem_busy));
            flush_i  = hz.branch_taken | (state == FLUSH);
            freeze_i = hz.mem_busy;
        end
    end

    // Performance counters: effective stall cycles and started flushes
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_i && !freeze_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (hz.branch_taken) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.fwdX_rs      = rst & fx_rs;
    assign hz.fwdX_rt      = rst & fx_rt;
    assign hz.fwdM_rs      = rst & fm_rs;
    assign hz.fwdM_rt      = rst & fm_rt;
    assign hz.stall        = stall_i;
    assign hz.stall_fd     = stall_i;
    assign hz.flush        = flush_i;
    assign hz.freeze       = freeze_i;
    assign hz.stall_cycles = stall_cnt_q;
    assign hz.flush_events = flush_cnt_q;

endmodule
